full_adder_unit: RTL and testbench
==================================

// Module: full_adder_unit
// PURPOSE
//  - WIDTH-bit binary adder: {carry_out, sum} = a + b + carry_in, registered on clk.
//  - WIDTH=1 is the classic 1-bit full adder: sum = a^b^carry_in, carry_out = majority(a,b,carry_in).
//  - Arithmetic leaf for datapath blocks; built as a ripple chain of 1-bit cells.
// PARAMETERS
//  - WIDTH  1  operand/sum bit width, legal range 1..64
// PORTS
//  - clk        in   1      single clock, all state rising-edge
//  - rst_n      in   1      asynchronous, active-low reset
//  - a          in   WIDTH  operand A, unsigned
//  - b          in   WIDTH  operand B, unsigned
//  - carry_in   in   1      carry into bit 0
//  - in_valid   in   1      operands valid this cycle; capture enable
//  - sum        out  WIDTH  registered sum bits
//  - carry_out  out  1      registered carry out of MSB
//  - out_valid  out  1      sum/carry_out hold a fresh result
//  - overflow   out  1      signed overflow, only with FULL_ADDER_UNIT_OVF_EN
// BEHAVIOUR
//  - Reset (rst_n=0, async assert, sync-safe deassert): sum=0, carry_out=0, out_valid=0, overflow=0.
//  - Latency 1 cycle: operands sampled with in_valid=1 at edge N -> result visible after edge N.
//  - in_valid=0 at an edge: sum/carry_out/overflow hold previous value; out_valid<=0.
//  - out_valid <= in_valid every edge; no back-pressure, no ready signal; back-to-back accepted.
//  - Arithmetic: full WIDTH+1-bit result, no truncation besides carry_out; modulo 2^WIDTH wrap in sum.
//  - Bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i; c_0 = carry_in; carry_out = c_WIDTH.
//  - X/Z on inputs with in_valid=0 must not disturb held outputs.
//  - Reset asserted mid-stream: outputs clear immediately; the in-flight result is discarded.
//  - No state machine; purely a registered combinational path.
// CONFIGURATION
//  - FULL_ADDER_UNIT_OVF_EN defined: overflow port present; overflow <= c_WIDTH ^ c_{WIDTH-1}
//    (two's-complement overflow), registered with sum, held when in_valid=0, 0 at reset.
//    For WIDTH=1, c_{WIDTH-1} is carry_in.
//  - Not defined: overflow port and its register absent; all other behaviour identical.
// STRUCTURE
//  - full_adder_unit_pkg: FA_MAX_WIDTH=64 constant, function fa_ref(a,b,cin) returning
//    {carry,sum} for benches.
//  - Sub-module fa_cell: combinational 1-bit full adder (a, b, cin -> s, cout); WIDTH
//    instances via generate, carry rippled LSB->MSB.
//  - Top: generate chain + output register bank + optional overflow register.
// TESTING
//  - WIDTH=1 exhaustive, in_valid=1, one vector per clk: (a,b,cin) 000->s0 c0, 001->s1 c0,
//    010->s1 c0, 011->s0 c1, 100->s1 c0, 101->s0 c1, 110->s0 c1, 111->s1 c1,
//    each seen one cycle after its capture edge.
//  - WIDTH=8: a=0xFF, b=0x00, cin=1 -> sum=0x00, carry_out=1; a=0x7F, b=0x01, cin=0 ->
//    sum=0x80, carry_out=0, overflow=1 (OVF_EN).
//  - Hold: capture a=0x05, b=0x03 (sum 0x08), then in_valid=0 with random a/b for 5 cycles ->
//    sum stays 0x08, out_valid=0.
//  - Reset mid-op: drive valid vectors, pull rst_n low between edges -> outputs 0 at once,
//    not waiting for clk; first valid after release yields the correct result.
//  - Random WIDTH=16, 10k vectors vs fa_ref, checked with 1-cycle latency; build with and
//    without FULL_ADDER_UNIT_OVF_EN.

Source files
------------

// File: rtl/full_adder_unit_pkg.sv
// Shared constants and a behavioural reference adder for the full_adder_unit slice.
package full_adder_unit_pkg;

  localparam int unsigned FA_MAX_WIDTH = 64;

  // Behavioural {carry, sum} of a + b + cin. Operands are zero-extended, so the
  // carry of a WIDTH-bit add is bit [WIDTH] of the result.
  function automatic logic [FA_MAX_WIDTH:0] fa_ref(
    input logic [FA_MAX_WIDTH-1:0] a,
    input logic [FA_MAX_WIDTH-1:0] b,
    input logic                    cin
  );
    return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/full_adder_unit_cell.sv
// Combinational 1-bit full adder cell used as the ripple-chain leaf.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_unit.sv
// Registered WIDTH-bit ripple-carry adder built from fa_cell instances.
// Define FULL_ADDER_UNIT_OVF_EN to add the registered signed-overflow output.
module full_adder_unit
  import full_adder_unit_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid
`ifdef FULL_ADDER_UNIT_OVF_EN
  ,
  output logic             overflow
`endif
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $error("full_adder_unit: WIDTH must be in 1..%0d", FA_MAX_WIDTH);
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_comb;

  assign c[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s_comb[i]),
      .cout (c[i+1])
    );
  end

  // NOTE: state uses <= so every flop samples pre-edge values; the missing else
  // on in_valid is a clock-enable hold, not a latch, because this is edge-triggered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= s_comb;
        carry_out <= c[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_UNIT_OVF_EN
  // Two's-complement overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (in_valid) begin
      overflow <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Scoreboard bench: WIDTH=1 and WIDTH=8 instances, directed vectors plus a short random run.
module tb_full_adder_unit;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, iv1 = 1'b0;
  logic       s1, co1, ovl1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0, iv8 = 1'b0;
  logic [7:0] s8;
  logic       co8, ovl8;
`ifdef FULL_ADDER_UNIT_OVF_EN
  logic       ov1, ov8;
`endif

  exp_t q1[$];
  exp_t q8[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  full_adder_unit #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a1),
    .b         (b1),
    .carry_in  (cin1),
    .in_valid  (iv1),
    .sum       (s1),
    .carry_out (co1),
    .out_valid (ovl1)
`ifdef FULL_ADDER_UNIT_OVF_EN
    ,
    .overflow  (ov1)
`endif
  );

  full_adder_unit #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a8),
    .b         (b8),
    .carry_in  (cin8),
    .in_valid  (iv8),
    .sum       (s8),
    .carry_out (co8),
    .out_valid (ovl8)
`ifdef FULL_ADDER_UNIT_OVF_EN
    ,
    .overflow  (ov8)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive1(input logic ai, input logic bi, input logic ci,
                        input logic es, input logic ec);
    exp_t e;
    @(negedge clk);
    a1 = ai; b1 = bi; cin1 = ci; iv1 = 1'b1;
    e.sum  = {7'b0, es};
    e.cout = ec;
    e.ovf  = ec ^ ci;
    q1.push_back(e);
  endtask

  task automatic drive8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                        input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    a8 = ai; b8 = bi; cin8 = ci; iv8 = 1'b1;
    e.sum  = es;
    e.cout = ec;
    e.ovf  = eo;
    q8.push_back(e);
  endtask

  // Monitors: pop one expectation per presented result, 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && ovl1) begin
        if (q1.size() == 0) begin
          check("w1_unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = q1.pop_front();
          check("w1_sum", {63'b0, s1}, {56'b0, e.sum});
          check("w1_cout", {63'b0, co1}, {63'b0, e.cout});
`ifdef FULL_ADDER_UNIT_OVF_EN
          check("w1_ovf", {63'b0, ov1}, {63'b0, e.ovf});
`endif
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && ovl8) begin
        if (q8.size() == 0) begin
          check("w8_unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = q8.pop_front();
          check("w8_sum", {56'b0, s8}, {56'b0, e.sum});
          check("w8_cout", {63'b0, co8}, {63'b0, e.cout});
`ifdef FULL_ADDER_UNIT_OVF_EN
          check("w8_ovf", {63'b0, ov8}, {63'b0, e.ovf});
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s_tab;
    logic [7:0] c_tab;
    logic [7:0] idx;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] full;
    s_tab = 8'b1001_0110;
    c_tab = 8'b1110_1000;

    #12;
    check("reset_w8_sum", {56'b0, s8}, 64'd0);
    check("reset_w8_cout", {63'b0, co8}, 64'd0);
    check("reset_w8_valid", {63'b0, ovl8}, 64'd0);
    check("reset_w1_valid", {63'b0, ovl1}, 64'd0);
`ifdef FULL_ADDER_UNIT_OVF_EN
    check("reset_w8_ovf", {63'b0, ov8}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive truth table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      idx = 8'(i);
      drive1(idx[2], idx[1], idx[0], s_tab[i], c_tab[i]);
    end
    @(negedge clk);
    iv1 = 1'b0;

    // WIDTH=8 directed boundaries, back-to-back.
    drive8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    drive8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    drive8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    drive8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    drive8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    drive8(8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1, 1'b0);
    drive8(8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1);

    // Hold: one capture, then idle cycles with junk operands.
    drive8(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1'b0;
      @(posedge clk);
      #2;
      check("hold_sum", {56'b0, s8}, 64'h08);
      check("hold_cout", {63'b0, co8}, 64'd0);
      check("hold_valid", {63'b0, ovl8}, 64'd0);
    end

    // Reset mid-stream: a visible result, an in-flight operand set, then async clear.
    drive8(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h40; cin8 = 1'b0; iv8 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_sum", {56'b0, s8}, 64'd0);
    check("midreset_cout", {63'b0, co8}, 64'd0);
    check("midreset_valid", {63'b0, ovl8}, 64'd0);
`ifdef FULL_ADDER_UNIT_OVF_EN
    check("midreset_ovf", {63'b0, ov8}, 64'd0);
`endif
    @(posedge clk);
    #2;
    check("inreset_sum", {56'b0, s8}, 64'd0);
    @(negedge clk);
    iv8 = 1'b0;
    rst_n = 1'b1;
    drive8(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);

    // Short random run against plain integer arithmetic.
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      drive8(ra, rb, rc, full[7:0], full[8],
             (ra[7] == rb[7]) && (full[7] != ra[7]));
    end
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    check("w1_drain", 64'(q1.size()), 64'd0);
    check("w8_drain", 64'(q8.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
